// File: rtl/i2c_pkg.sv
// rtl/i2c_pkg.sv - shared I2C state encoding and bus bit constants
package i2c_pkg;

  typedef enum logic [3:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    PTR,
    PTR_ACK,
    WDATA,
    WDATA_ACK,
    RDATA,
    RDATA_ACK
  } i2c_state_e;

  localparam logic I2C_ACK  = 1'b0;
  localparam logic I2C_NACK = 1'b1;

  // R/W bit that follows the 7-bit address
  localparam logic I2C_RD = 1'b1;
  localparam logic I2C_WR = 1'b0;

endpackage

// File: rtl/i2c_bus_sync.sv
// rtl/i2c_bus_sync.sv - SCL/SDA synchronisers and START/STOP/edge event generation
module i2c_bus_sync (
  input  logic clk,
  input  logic reset_n,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda,
  output logic scl_rise,
  output logic scl_fall,
  output logic start,
  output logic stop
);

  logic scl_ff1, scl_ff2, scl_hist;
  logic sda_ff1, sda_ff2, sda_hist;

  assign sda = sda_ff2;

  // Two-flop synchronisers plus one history flop; reset to the idle (released) bus level
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      scl_ff1  <= 1'b1;
      scl_ff2  <= 1'b1;
      scl_hist <= 1'b1;
      sda_ff1  <= 1'b1;
      sda_ff2  <= 1'b1;
      sda_hist <= 1'b1;
    end else begin
      scl_ff1  <= scl_i;
      scl_ff2  <= scl_ff1;
      scl_hist <= scl_ff2;
      sda_ff1  <= sda_i;
      sda_ff2  <= sda_ff1;
      sda_hist <= sda_ff2;
    end
  end

  // Registered bus events; an SDA edge qualifies as START/STOP against the current SCL level,
  // so an SCL rise landing on the same clk is reported alongside and handled first downstream
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      scl_rise <= 1'b0;
      scl_fall <= 1'b0;
      start    <= 1'b0;
      stop     <= 1'b0;
    end else begin
      scl_rise <= scl_ff2 & ~scl_hist;
      scl_fall <= ~scl_ff2 & scl_hist;
      start    <= sda_hist & ~sda_ff2 & scl_ff2;
      stop     <= ~sda_hist & sda_ff2 & scl_ff2;
    end
  end

endmodule

// File: rtl/i2c_target_regs.sv
// rtl/i2c_target_regs.sv - I2C target serving a byte register file with pointer auto-increment
module i2c_target_regs
  import i2c_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             scl_i,
  input  logic             sda_i,
  output logic             sda_oe,
  input  logic [6:0]       own_addr,
  input  logic             ld_en,
  input  logic [PTR_W-1:0] ld_addr,
  input  logic [7:0]       ld_data,
  output logic             wr_strobe,
  output logic [PTR_W-1:0] wr_addr,
  output logic [7:0]       wr_data,
  output logic             busy
);

  localparam logic [8:0] DEPTH9 = 9'(DEPTH);

  logic sda, scl_rise, scl_fall, start, stop;

  i2c_bus_sync u_sync (
    .clk      (clk),
    .reset_n  (reset_n),
    .scl_i    (scl_i),
    .sda_i    (sda_i),
    .sda      (sda),
    .scl_rise (scl_rise),
    .scl_fall (scl_fall),
    .start    (start),
    .stop     (stop)
  );

  i2c_state_e       state, state_nxt;
  logic [2:0]       bit_cnt, bit_cnt_nxt;
  logic [7:0]       shreg, shreg_nxt;
  logic [7:0]       txbyte, txbyte_nxt;
  logic [PTR_W-1:0] ptr, ptr_nxt, ptr_inc;
  logic             pend, pend_nxt;   // a full byte has been shifted in, ACK decision due at next fall
  logic             rw, rw_nxt;
  logic             busy_nxt, sda_oe_nxt;
  logic             wr_en;
  logic [PTR_W-1:0] wr_idx;
  logic [7:0]       wr_byte;
  logic [7:0]       regs [DEPTH];
  logic [7:0]       rx_byte;

  assign rx_byte = {shreg[6:0], sda};
  assign ptr_inc = ptr + 1'b1;

  // State and bus-side registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      bit_cnt <= '0;
      shreg   <= '0;
      txbyte  <= '0;
      ptr     <= '0;
      pend    <= 1'b0;
      rw      <= I2C_WR;
      busy    <= 1'b0;
      sda_oe  <= 1'b0;
    end else begin
      state   <= state_nxt;
      bit_cnt <= bit_cnt_nxt;
      shreg   <= shreg_nxt;
      txbyte  <= txbyte_nxt;
      ptr     <= ptr_nxt;
      pend    <= pend_nxt;
      rw      <= rw_nxt;
      busy    <= busy_nxt;
      sda_oe  <= sda_oe_nxt;
    end
  end

  // Next-state logic: SCL events first, then START overrides, STOP overrides everything
  always_comb begin
    state_nxt   = state;
    bit_cnt_nxt = bit_cnt;
    shreg_nxt   = shreg;
    txbyte_nxt  = txbyte;
    ptr_nxt     = ptr;
    pend_nxt    = pend;
    rw_nxt      = rw;
    busy_nxt    = busy;
    sda_oe_nxt  = sda_oe;
    wr_en       = 1'b0;
    wr_idx      = ptr;
    wr_byte     = shreg;

    if (stop) begin
      state_nxt  = IDLE;
      sda_oe_nxt = 1'b0;
      busy_nxt   = 1'b0;
      pend_nxt   = 1'b0;
    end else begin
      if (scl_rise && (state == ADDR || state == PTR || state == WDATA)) begin
        shreg_nxt   = rx_byte;
        bit_cnt_nxt = bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) pend_nxt = 1'b1;
      end

      case (state)
        IDLE: ;
        ADDR: begin
          if (scl_rise && bit_cnt == 3'd7) begin
            if (rx_byte[7:1] == own_addr) begin
              rw_nxt = rx_byte[0];
            end else begin
              state_nxt = IDLE;
              busy_nxt  = 1'b0;
              pend_nxt  = 1'b0;
            end
          end else if (scl_fall && pend) begin
            pend_nxt   = 1'b0;
            sda_oe_nxt = ~I2C_ACK;
            busy_nxt   = 1'b1;
            state_nxt  = ADDR_ACK;
          end
        end
        ADDR_ACK: begin
          if (scl_fall) begin
            bit_cnt_nxt = '0;
            if (rw == I2C_RD) begin
              state_nxt  = RDATA;
              txbyte_nxt = regs[ptr];
              sda_oe_nxt = ~regs[ptr][7];
            end else begin
              state_nxt  = PTR;
              sda_oe_nxt = 1'b0;
            end
          end
        end
        PTR: begin
          if (scl_fall && pend) begin
            pend_nxt = 1'b0;
            if ({1'b0, shreg} < DEPTH9) begin
              sda_oe_nxt = ~I2C_ACK;
              ptr_nxt    = shreg[PTR_W-1:0];
              state_nxt  = PTR_ACK;
            end else begin
              sda_oe_nxt = ~I2C_NACK;
              busy_nxt   = 1'b0;
              state_nxt  = IDLE;
            end
          end
        end
        PTR_ACK, WDATA_ACK: begin
          if (scl_fall) begin
            sda_oe_nxt  = 1'b0;
            bit_cnt_nxt = '0;
            state_nxt   = WDATA;
          end
        end
        WDATA: begin
          if (scl_fall && pend) begin
            pend_nxt   = 1'b0;
            sda_oe_nxt = ~I2C_ACK;
            wr_en      = 1'b1;
            ptr_nxt    = ptr_inc;
            state_nxt  = WDATA_ACK;
          end
        end
        RDATA: begin
          if (scl_rise) begin
            bit_cnt_nxt = bit_cnt + 3'd1;
          end else if (scl_fall) begin
            if (bit_cnt == 3'd0) begin
              sda_oe_nxt = 1'b0;
              state_nxt  = RDATA_ACK;
            end else begin
              sda_oe_nxt = ~txbyte[3'd7 - bit_cnt];
            end
          end
        end
        RDATA_ACK: begin
          if (scl_rise) begin
            ptr_nxt = ptr_inc;
            if (sda == I2C_ACK) begin
              txbyte_nxt = regs[ptr_inc];
              pend_nxt   = 1'b1;
            end else begin
              busy_nxt  = 1'b0;
              state_nxt = IDLE;
            end
          end else if (scl_fall && pend) begin
            pend_nxt    = 1'b0;
            bit_cnt_nxt = '0;
            sda_oe_nxt  = ~txbyte[7];
            state_nxt   = RDATA;
          end
        end
        default: state_nxt = IDLE;
      endcase

      if (start) begin
        state_nxt   = ADDR;
        bit_cnt_nxt = '0;
        pend_nxt    = 1'b0;
        sda_oe_nxt  = 1'b0;
      end
    end
  end

  // Register file: local preload first so a same-index bus write lands last and wins
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else begin
      if (ld_en) regs[ld_addr] <= ld_data;
      if (wr_en) regs[wr_idx] <= wr_byte;
    end
  end

  // Local write notification, one clk per byte written from the bus
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_strobe <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
    end else begin
      wr_strobe <= wr_en;
      if (wr_en) begin
        wr_addr <= wr_idx;
        wr_data <= wr_byte;
      end
    end
  end

endmodule

// File: tb/tb_i2c_target_regs.sv
// tb/tb_i2c_target_regs.sv - directed bench for i2c_target_regs with write/read scoreboards
module tb_i2c_target_regs;

  localparam int Q = 6;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       scl;
  logic       m_sda_low;
  logic       sda_bus;
  logic       sda_oe;
  logic       ld_en;
  logic [1:0] ld_addr;
  logic [7:0] ld_data;
  logic       wr_strobe;
  logic [1:0] wr_addr;
  logic [7:0] wr_data;
  logic       busy;

  int tests = 0;
  int fails = 0;
  logic oe_seen;
  logic [15:0] exp_q[$];
  logic [7:0]  rd_q[$];

  assign sda_bus = ~(m_sda_low | sda_oe);

  always #5 clk = ~clk;

  i2c_target_regs #(.DEPTH(4)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .scl_i     (scl),
    .sda_i     (sda_bus),
    .sda_oe    (sda_oe),
    .own_addr  (7'h55),
    .ld_en     (ld_en),
    .ld_addr   (ld_addr),
    .ld_data   (ld_data),
    .wr_strobe (wr_strobe),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .busy      (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bit_cycle(input logic b, output logic smp);
    tick(Q); m_sda_low = ~b;
    tick(Q); scl = 1'b1;
    tick(Q); smp = sda_bus;
    tick(Q); scl = 1'b0;
  endtask

  task automatic i2c_start();
    tick(Q); m_sda_low = 1'b0;
    tick(Q); scl = 1'b1;
    tick(Q); m_sda_low = 1'b1;
    tick(Q); scl = 1'b0;
  endtask

  task automatic i2c_stop();
    tick(Q); m_sda_low = 1'b1;
    tick(Q); scl = 1'b1;
    tick(Q); m_sda_low = 1'b0;
    tick(Q);
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) bit_cycle(b[i], s);
    bit_cycle(1'b1, ack);
  endtask

  task automatic recv_byte(input logic ack_bit, output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      bit_cycle(1'b1, s);
      d[i] = s;
    end
    bit_cycle(ack_bit, s);
  endtask

  task automatic preload(input logic [1:0] a, input logic [7:0] d);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    tick(1);
    ld_en = 1'b0;
  endtask

  task automatic read_check(input string tag, input logic [7:0] exp);
    logic [7:0] d;
    rd_q.push_back(exp);
    recv_byte(1'b1, d);
    check(tag, d, rd_q.pop_front());
  endtask

  // Write-strobe scoreboard and SDA-drive watcher
  always @(negedge clk) begin
    if (sda_oe) oe_seen = 1'b1;
    if (reset_n && wr_strobe) begin
      if (exp_q.size() == 0) check("strobe_unexpected", {6'd0, wr_addr, wr_data}, 32'hFFFF_FFFF);
      else check("strobe", {6'd0, wr_addr, wr_data}, exp_q.pop_front());
    end
  end

  initial begin
    logic ack;
    logic s;
    reset_n = 1'b0; scl = 1'b1; m_sda_low = 1'b0;
    ld_en = 1'b0; ld_addr = '0; ld_data = '0; oe_seen = 1'b0;
    tick(3);
    check("rst_sda_oe", sda_oe, 0);
    check("rst_busy", busy, 0);
    check("rst_wr_strobe", wr_strobe, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_wr_data", wr_data, 0);
    reset_n = 1'b1;
    tick(5);

    // single byte write to reg 2
    i2c_start();
    send_byte(8'hAA, ack); check("w_addr_ack", ack, 0);
    check("w_busy", busy, 1);
    send_byte(8'h02, ack); check("w_ptr_ack", ack, 0);
    exp_q.push_back({8'd2, 8'h2B});
    send_byte(8'h2B, ack); check("w_data_ack", ack, 0);
    i2c_stop();
    check("w_busy_after_stop", busy, 0);

    // preload, pointer write, repeated START, read one byte with NACK
    preload(2'd3, 8'h93);
    preload(2'd0, 8'h4C);
    i2c_start();
    send_byte(8'hAA, ack); check("r_addr_ack", ack, 0);
    send_byte(8'h03, ack); check("r_ptr_ack", ack, 0);
    i2c_start();
    send_byte(8'hAB, ack); check("r_raddr_ack", ack, 0);
    read_check("r_byte", 8'h93);
    check("r_oe_after_nack", sda_oe, 0);
    check("r_busy_after_nack", busy, 0);
    i2c_stop();
    i2c_start();
    send_byte(8'hAB, ack); check("r2_addr_ack", ack, 0);
    read_check("r2_ptr_wrapped", 8'h4C);
    i2c_stop();

    // foreign address is ignored
    oe_seen = 1'b0;
    i2c_start();
    send_byte(8'hA8, ack); check("mis_addr_nack", ack, 1);
    check("mis_busy", busy, 0);
    send_byte(8'h11, ack); check("mis_data_nack", ack, 1);
    i2c_stop();
    check("mis_oe_never", oe_seen, 0);

    // pointer wrap across two data bytes
    i2c_start();
    send_byte(8'hAA, ack); check("wrap_addr_ack", ack, 0);
    send_byte(8'h03, ack); check("wrap_ptr_ack", ack, 0);
    exp_q.push_back({8'd3, 8'hA1});
    send_byte(8'hA1, ack); check("wrap_d1_ack", ack, 0);
    exp_q.push_back({8'd0, 8'hA2});
    send_byte(8'hA2, ack); check("wrap_d2_ack", ack, 0);
    i2c_stop();

    // out-of-range pointer is NACKed and following data ignored
    i2c_start();
    send_byte(8'hAA, ack); check("oor_addr_ack", ack, 0);
    send_byte(8'h07, ack); check("oor_ptr_nack", ack, 1);
    check("oor_busy", busy, 0);
    send_byte(8'h33, ack); check("oor_data_nack", ack, 1);
    i2c_stop();

    // reset while driving bit 5 of a read byte (0xC5: bits 7,6 = 1, bit 5 = 0)
    preload(2'd1, 8'hC5);
    i2c_start();
    send_byte(8'hAA, ack); check("rr_addr_ack", ack, 0);
    send_byte(8'h01, ack); check("rr_ptr_ack", ack, 0);
    i2c_start();
    send_byte(8'hAB, ack); check("rr_raddr_ack", ack, 0);
    bit_cycle(1'b1, s); check("rr_bit7", s, 1);
    bit_cycle(1'b1, s); check("rr_bit6", s, 1);
    tick(Q); m_sda_low = 1'b0;
    tick(Q); scl = 1'b1;
    tick(Q); check("rr_oe_bit5", sda_oe, 1);
    reset_n = 1'b0;
    #1;
    check("rr_oe_reset", sda_oe, 0);
    check("rr_busy_reset", busy, 0);
    check("rr_strobe_reset", wr_strobe, 0);
    check("rr_wr_addr_reset", wr_addr, 0);
    check("rr_wr_data_reset", wr_data, 0);
    tick(3);
    reset_n = 1'b1;
    tick(Q);
    i2c_start();
    send_byte(8'hAA, ack); check("post_addr_ack", ack, 0);
    send_byte(8'h01, ack); check("post_ptr_ack", ack, 0);
    exp_q.push_back({8'd1, 8'h5A});
    send_byte(8'h5A, ack); check("post_data_ack", ack, 0);
    i2c_stop();

    // register file was cleared by reset
    i2c_start();
    send_byte(8'hAA, ack); check("clr_addr_ack", ack, 0);
    send_byte(8'h02, ack); check("clr_ptr_ack", ack, 0);
    i2c_start();
    send_byte(8'hAB, ack); check("clr_raddr_ack", ack, 0);
    read_check("clr_reg2", 8'h00);
    i2c_stop();

    tick(10);
    check("strobe_q_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/i2c_target_regs.md
Name: i2c_target_regs

Overview:
- I2C responder (target) that answers the controller side of top_i2c over a shared open-drain SCL/SDA pair.
- Samples SCL/SDA with the system clock, detects START, repeated START and STOP, matches its 7-bit address, and ACKs on SDA.
- Serves a small byte register file with a pointer-then-data protocol and auto-increment.
- The local side can preload read data and receives a strobe for every byte the controller writes.

Parameters:
- DEPTH, 4, number of byte registers; power of two, 2..256.
- PTR_W, $clog2(DEPTH), register pointer width.

Ports:
- clk  input  1  system clock; SCL high and low phases each ≥ 4 clk periods.
- reset_n  input  1  asynchronous, active-low reset.
- scl_i  input  1  bus SCL level (asynchronous).
- sda_i  input  1  bus SDA level (asynchronous).
- sda_oe  output  1  1 = pull SDA low; 0 = release.
- own_addr  input  7  target address; static while busy.
- ld_en  input  1  local preload strobe.
- ld_addr  input  PTR_W  preload register index.
- ld_data  input  8  preload value.
- wr_strobe  output  1  one-cycle pulse per data byte written by the controller.
- wr_addr  output  PTR_W  register index for wr_strobe.
- wr_data  output  8  byte for wr_strobe.
- busy  output  1  high from an address-matched START until STOP, NACK or mismatch.

Behaviour:
- Reset (async assert, sync deassert use) clears:
  - sda_oe, wr_strobe, busy, wr_addr, wr_data = 0.
  - Pointer = 0, register file = 0, state = IDLE.
- Reset mid-transfer releases SDA immediately.
- Synchronisers: 2-flop on scl_i and sda_i, plus one history flop for edge detection.
  - scl_rise / scl_fall are registered events, 3 clk after the pin edge.
- Bus conditions:
  - START = SDA falling while SCL high.
  - STOP = SDA rising while SCL high.
  - START in any state (repeated START) → ADDR with bit count 0; pointer is kept.
  - STOP in any state → IDLE, sda_oe = 0, busy = 0.
- Bit timing:
  - Receive bits are sampled MSB first on scl_rise.
  - sda_oe changes only on scl_fall.
- States:
  - IDLE → ADDR on START.
  - ADDR: shift 8 bits (7 address + R/W).
    - On a match, at the next scl_fall assert ACK → ADDR_ACK and set busy.
    - On a mismatch → IDLE; no ACK, bus ignored until the next START.
  - ADDR_ACK: at the scl_fall ending ACK, release SDA → PTR if W.
    - If R → RDATA, and drive bit 7 of reg[ptr] on the same fall.
  - PTR: shift 8 bits.
    - Value < DEPTH → ACK, load pointer, → WDATA.
    - Value ≥ DEPTH → NACK (release), → IDLE.
  - WDATA: shift 8 bits, then ACK.
    - On the ACK's scl_fall: reg[ptr] ← byte, pulse wr_strobe for 1 clk with wr_addr = ptr and wr_data = byte.
    - Pointer increments modulo DEPTH.
    - Stay in WDATA for further bytes.
  - RDATA: drive reg[ptr] MSB first (sda_oe = ~bit), then release for the controller's ACK.
    - Sample ACK on scl_rise.
    - ACK (SDA low) → pointer++ mod DEPTH, load the next byte, continue.
    - NACK → pointer++, release, → IDLE.
- Simultaneous events:
  - An I2C write and ld_en to the same index in the same clk: the I2C write wins.
  - ld_en to the byte currently being shifted out does not alter the byte in flight.
  - START and STOP cannot coincide; if the SDA edge and SCL edge land on the same synchronised clk, the SCL edge is processed first.
- Byte/bit counters are 3 bits and wrap naturally; no overflow states.

Decomposition:
- Shared package i2c_pkg holds:
  - the state enum (IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK);
  - I2C_ACK = 1'b0 and I2C_NACK = 1'b1;
  - the R/W bit encoding (1 = read).
- One sub-module, i2c_bus_sync: synchronisers plus START/STOP/scl_rise/scl_fall event generation; reusable by the controller.

Test Plan:
- own_addr = 7'h55; controller writes addr 0x55 W, ptr 0x02, data 0x2B, STOP → three ACKs; wr_strobe once with wr_addr = 2, wr_data = 0x2B; busy falls after STOP.
- ld_en reg[3] = 0x93; controller writes 0x55 W, ptr 0x03, repeated START, 0x55 R, reads 1 byte, NACK → SDA carries 0x93; sda_oe = 0 after NACK; pointer = 0.
- Controller sends address 0x54 W → no ACK (sda_oe stays 0 throughout), busy stays 0, no wr_strobe.
- DEPTH = 4: ptr 0x03, data 0xA1, 0xA2 → wr_strobe (3, 0xA1) then (0, 0xA2); pointer wraps.
- ptr 0x07 with DEPTH = 4 → pointer byte NACKed, state IDLE, following data ignored.
- reset_n low while driving bit 5 of a read byte → sda_oe = 0 immediately; all outputs at reset values; a fresh write of 0x55/0x01/0x5A after release is ACKed.
